// File: rtl/reg_file_demux_pkg.sv
// Shared types and defaults for the register-file write demux and its bus interface.
package reg_file_demux_pkg;

  localparam int unsigned N_DEFAULT     = 16;
  localparam int unsigned NREGS_DEFAULT = 8;
  localparam int unsigned CNT_W         = 16;

  typedef logic [15:0] word_t;
  typedef logic [2:0]  reg_sel_t;

endpackage

// File: rtl/reg_file_demux_if.sv
// Bus-side write port, two read ports and debug observation signals of the register file.
interface reg_file_demux_if
  import reg_file_demux_pkg::*;
#(
  parameter int unsigned N     = N_DEFAULT,
  parameter int unsigned NREGS = NREGS_DEFAULT,
  parameter int unsigned SEL_W = $clog2(NREGS)
);

  logic             LD_REG;
  logic [SEL_W-1:0] DR;
  logic [SEL_W-1:0] SR1;
  logic [SEL_W-1:0] SR2;
  logic [N-1:0]     Bus_In;
  logic [N-1:0]     SR1_Out;
  logic [N-1:0]     SR2_Out;
  logic [NREGS-1:0] Ld_OneHot;
  logic [CNT_W-1:0] Wr_Count;

  modport master (
    output LD_REG, DR, SR1, SR2, Bus_In,
    input  SR1_Out, SR2_Out, Ld_OneHot, Wr_Count
  );

  modport slave (
    input  LD_REG, DR, SR1, SR2, Bus_In,
    output SR1_Out, SR2_Out, Ld_OneHot, Wr_Count
  );

endinterface

// File: rtl/reg_file_demux_decoder_demux.sv
// Binary select to one-hot strobe decoder; the enable gates the decode so an
// unknown select with enable low never produces a strobe.
module decoder_demux #(
  parameter int unsigned NREGS = 8,
  parameter int unsigned SEL_W = $clog2(NREGS)
) (
  input  logic [SEL_W-1:0] sel_i,
  input  logic             en_i,
  output logic [NREGS-1:0] onehot_o
);

  always_comb begin
    onehot_o = '0;
    if (en_i) begin
      onehot_o[sel_i] = 1'b1;
    end
  end

endmodule

// File: rtl/reg_file_demux.sv
// General register file: one-hot demuxed bus writes, two combinational read ports,
// registered write strobes and a write counter.
module reg_file_demux
  import reg_file_demux_pkg::*;
#(
  parameter int unsigned N      = N_DEFAULT,
  parameter int unsigned NREGS  = NREGS_DEFAULT,
  parameter int unsigned SEL_W  = $clog2(NREGS),
  parameter bit          BYPASS = 1'b0
) (
  input logic              Clk,
  input logic              Reset,
  reg_file_demux_if.slave  bus
);

  logic [N-1:0]     regs_q [NREGS];
  logic [NREGS-1:0] strobe;
  logic [NREGS-1:0] ld_onehot_q;
  logic [CNT_W-1:0] wr_count_q;

  decoder_demux #(
    .NREGS (NREGS),
    .SEL_W (SEL_W)
  ) u_decoder (
    .sel_i    (bus.DR),
    .en_i     (bus.LD_REG),
    .onehot_o (strobe)
  );

  for (genvar g = 0; g < NREGS; g++) begin : gen_regs
    always_ff @(posedge Clk) begin
      if (Reset) begin
        regs_q[g] <= '0;
      end else if (strobe[g]) begin
        regs_q[g] <= bus.Bus_In;
      end
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      ld_onehot_q <= '0;
      wr_count_q  <= '0;
    end else begin
      ld_onehot_q <= strobe;
      if (bus.LD_REG) begin
        wr_count_q <= wr_count_q + 1'b1;
      end
    end
  end

  // With bypass, a read of the register being written forwards the bus value.
  always_comb begin
    bus.SR1_Out = regs_q[bus.SR1];
    bus.SR2_Out = regs_q[bus.SR2];
    if (BYPASS && bus.LD_REG && (bus.SR1 == bus.DR)) begin
      bus.SR1_Out = bus.Bus_In;
    end
    if (BYPASS && bus.LD_REG && (bus.SR2 == bus.DR)) begin
      bus.SR2_Out = bus.Bus_In;
    end
  end

  assign bus.Ld_OneHot = ld_onehot_q;
  assign bus.Wr_Count  = wr_count_q;

endmodule
